// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma reflector stage: default character base,
// configuration FSM states and the symbol-index width helper.
package enigma_pkg;

    localparam logic [7:0] BASE_DEFAULT = 8'h41;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_LOAD,
        CFG_CHECK
    } cfg_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int sym_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wiring_checker.sv
// Per-cycle wiring validation: tracks symbols already seen, accumulates the
// rejection flag and generates the inverse-table write for each entry.
module wiring_checker
    import enigma_pkg::*;
#(
    parameter int N                  = 26,
    parameter bit REQUIRE_INVOLUTION = 1'b1,
    localparam int SW                = sym_width(N)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic [SW-1:0] idx,
    input  logic [SW-1:0] entry,
    input  logic [SW-1:0] partner,
    output logic          err_total,
    output logic          inv_we,
    output logic [SW-1:0] inv_addr,
    output logic [SW-1:0] inv_data
);

    logic [N-1:0] seen;
    logic [N-1:0] seen_cur;
    logic [N-1:0] seen_next;
    logic         err_acc;
    logic         first;
    logic         in_range;
    logic         dup;
    logic         inv_fail;
    logic         err_now;

    // Index 0 starts a fresh pass, so stale history from a previous bank is ignored.
    always_comb begin
        first     = (idx == '0);
        seen_cur  = first ? '0 : seen;
        in_range  = ({1'b0, entry} < (SW+1)'(N));
        dup       = 1'b0;
        seen_next = seen_cur;
        if (in_range) begin
            dup             = seen_cur[entry];
            seen_next[entry] = 1'b1;
        end
        inv_fail = 1'b0;
        if (REQUIRE_INVOLUTION) begin
            inv_fail = (entry == idx) || (in_range && (partner != idx));
        end
        err_now   = !in_range || dup || inv_fail;
        err_total = (first ? 1'b0 : err_acc) | err_now;
    end

    assign inv_we   = step && in_range;
    assign inv_addr = entry;
    assign inv_data = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen    <= '0;
            err_acc <= 1'b0;
        end else if (step) begin
            seen    <= seen_next;
            err_acc <= err_total;
        end
    end

endmodule

// File: rtl/reflector_bank.sv
// Multi-bank reflector: serially loaded wiring tables, validated on the fly,
// substituting characters forward or inverse through a 1-cycle valid/ready stage.
module reflector_bank
    import enigma_pkg::*;
#(
    parameter int           N                  = 26,
    parameter int           W                  = 8,
    parameter logic [W-1:0] BASE               = W'(BASE_DEFAULT),
    parameter int           BANKS              = 2,
    parameter bit           REQUIRE_INVOLUTION = 1'b1,
    localparam int          SW                 = sym_width(N),
    localparam int          BW                 = sym_width(BANKS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [BW-1:0]    cfg_bank,
    input  logic             cfg_valid,
    input  logic [SW-1:0]    cfg_data,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [BANKS-1:0] bank_ok,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     din,
    input  logic [BW-1:0]    in_bank,
    input  logic             dec,
    output logic [W-1:0]     dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic [W-1:0]  N_CHAR   = W'(N);

    cfg_state_t state;
    cfg_state_t next_state;

    logic [BW-1:0] ld_bank;
    logic [SW-1:0] idx;
    logic [SW-1:0] tbl [BANKS][N];
    logic [SW-1:0] inv [BANKS][N];

    logic          start_ok;
    logic          load_we;
    logic          check_step;
    logic          last_idx;
    logic [SW-1:0] chk_entry;
    logic [SW-1:0] chk_partner;
    logic          chk_err;
    logic          inv_we;
    logic [SW-1:0] inv_addr;
    logic [SW-1:0] inv_data;

    logic [W-1:0]  sym_off;
    logic [SW-1:0] sym;
    logic          bank_sel_ok;
    logic          accept;
    logic [SW-1:0] mapped;
    logic [W-1:0]  next_dout;
    logic          next_err;

    assign start_ok    = cfg_start && ({1'b0, cfg_bank} < (BW+1)'(BANKS));
    assign cfg_busy    = (state != CFG_IDLE);
    assign load_we     = (state == CFG_LOAD) && cfg_valid;
    assign check_step  = (state == CFG_CHECK);
    assign last_idx    = (idx == LAST_IDX);
    assign chk_entry   = tbl[ld_bank][idx];
    assign chk_partner = ({1'b0, chk_entry} < (SW+1)'(N)) ? tbl[ld_bank][chk_entry] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CFG_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            CFG_IDLE:  if (start_ok) next_state = CFG_LOAD;
            CFG_LOAD:  if (cfg_valid && last_idx) next_state = CFG_CHECK;
            CFG_CHECK: if (last_idx) next_state = CFG_IDLE;
            default:   next_state = CFG_IDLE;
        endcase
    end

    // The bank under configuration is marked unusable as soon as loading starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_bank  <= '0;
            idx      <= '0;
            bank_ok  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                CFG_IDLE: begin
                    if (start_ok) begin
                        ld_bank           <= cfg_bank;
                        idx               <= '0;
                        bank_ok[cfg_bank] <= 1'b0;
                    end
                end
                CFG_LOAD: begin
                    if (cfg_valid) idx <= last_idx ? '0 : idx + SW'(1);
                end
                CFG_CHECK: begin
                    idx <= last_idx ? '0 : idx + SW'(1);
                    if (last_idx) begin
                        cfg_done         <= 1'b1;
                        cfg_err          <= chk_err;
                        bank_ok[ld_bank] <= !chk_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table storage is deliberately left unreset; bank_ok guards its use.
    always_ff @(posedge clk) begin
        if (!reset && load_we) tbl[ld_bank][idx] <= cfg_data;
        if (!reset && inv_we)  inv[ld_bank][inv_addr] <= inv_data;
    end

    wiring_checker #(
        .N                  (N),
        .REQUIRE_INVOLUTION (REQUIRE_INVOLUTION)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .step      (check_step),
        .idx       (idx),
        .entry     (chk_entry),
        .partner   (chk_partner),
        .err_total (chk_err),
        .inv_we    (inv_we),
        .inv_addr  (inv_addr),
        .inv_data  (inv_data)
    );

    assign sym_off     = din - BASE;
    assign sym         = sym_off[SW-1:0];
    assign bank_sel_ok = ({1'b0, in_bank} < (BW+1)'(BANKS)) && bank_ok[in_bank];
    assign in_ready    = !cfg_busy && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;

    // Characters below BASE wrap to large offsets and pass through untouched.
    always_comb begin
        next_dout = din;
        next_err  = 1'b0;
        mapped    = '0;
        if (sym_off < N_CHAR) begin
            if (!bank_sel_ok) begin
                next_err = 1'b1;
            end else begin
                mapped    = dec ? inv[in_bank][sym] : tbl[in_bank][sym];
                next_dout = BASE + W'(mapped);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout      <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            dout      <= next_dout;
            out_valid <= 1'b1;
            out_err   <= next_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reflector_bank.sv
// Bench for reflector_bank: an involution-checking and a permutation-only
// instance share all inputs and are compared against a table-level model.
module tb_reflector_bank;

    localparam int          N    = 26;
    localparam logic [7:0]  BASE = 8'h41;

    logic       clk;
    logic       reset;
    logic       cfg_start;
    logic [0:0] cfg_bank;
    logic       cfg_valid;
    logic [4:0] cfg_data;
    logic       in_valid;
    logic [7:0] din;
    logic [0:0] in_bank;
    logic       dec;
    logic       out_ready;

    logic       a_cfg_busy, a_cfg_done, a_cfg_err, a_in_ready, a_out_valid, a_out_err;
    logic [1:0] a_bank_ok;
    logic [7:0] a_dout;
    logic       b_cfg_busy, b_cfg_done, b_cfg_err, b_in_ready, b_out_valid, b_out_err;
    logic [1:0] b_bank_ok;
    logic [7:0] b_dout;

    reflector_bank #(
        .N(N), .W(8), .BASE(BASE), .BANKS(2), .REQUIRE_INVOLUTION(1'b1)
    ) dut_inv (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_bank(cfg_bank), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done), .cfg_err(a_cfg_err), .bank_ok(a_bank_ok),
        .in_valid(in_valid), .in_ready(a_in_ready), .din(din), .in_bank(in_bank), .dec(dec),
        .dout(a_dout), .out_valid(a_out_valid), .out_ready(out_ready), .out_err(a_out_err)
    );

    reflector_bank #(
        .N(N), .W(8), .BASE(BASE), .BANKS(2), .REQUIRE_INVOLUTION(1'b0)
    ) dut_perm (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_bank(cfg_bank), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done), .cfg_err(b_cfg_err), .bank_ok(b_bank_ok),
        .in_valid(in_valid), .in_ready(b_in_ready), .din(din), .in_bank(in_bank), .dec(dec),
        .dout(b_dout), .out_valid(b_out_valid), .out_ready(out_ready), .out_err(b_out_err)
    );

    typedef struct {
        logic [7:0] din;
        int         bank;
        bit         dec;
        logic [7:0] exp_dout;
        bit         exp_err;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;
    int cur [N];
    int mtbl [2][N];
    bit mok [2][2];
    vec_t vecs [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Acceptance rules stated over whole tables: permutation, then involution.
    function automatic bit model_reject(input bit invol);
        int cnt [N];
        for (int v = 0; v < N; v++) cnt[v] = 0;
        for (int i = 0; i < N; i++) begin
            if (cur[i] < 0 || cur[i] >= N) return 1'b1;
            cnt[cur[i]]++;
        end
        for (int v = 0; v < N; v++) if (cnt[v] != 1) return 1'b1;
        if (invol) begin
            for (int i = 0; i < N; i++) if (cur[i] == i || cur[cur[i]] != i) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [8:0] model_out(input logic [7:0] c, input int bank, input bit d, input int variant);
        logic [7:0] s;
        s = c - BASE;
        if (s >= 8'd26) return {1'b0, c};
        if (!mok[variant][bank]) return {1'b1, c};
        if (!d) return {1'b0, BASE + 8'(mtbl[bank][s])};
        for (int j = 0; j < N; j++) if (mtbl[bank][j] == int'(s)) return {1'b0, BASE + 8'(j)};
        return {1'b0, c};
    endfunction

    task automatic gen_table(input int mode);
        int p [N];
        int j, t;
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        if (mode == 0) begin
            for (int k = 0; k < N; k += 2) begin
                cur[p[k]] = p[k+1];
                cur[p[k+1]] = p[k];
            end
        end else begin
            for (int i = 0; i < N; i++) cur[i] = p[i];
            if (mode == 2) cur[$urandom_range(0, N-1)] = $urandom_range(0, 31);
        end
    endtask

    task automatic load_bank(input int bank, input bit gaps, input int restart_at);
        int k;
        bit rej0, rej1;
        cfg_bank = bank[0];
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        mok[0][bank] = 1'b0;
        mok[1][bank] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gaps && (i % 4 == 2)) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = cur[i][4:0];
            if (i == restart_at) begin
                cfg_start = 1'b1;
                cfg_bank  = ~bank[0];
            end
            tick();
            cfg_start = 1'b0;
            cfg_bank  = bank[0];
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < N; i++) mtbl[bank][i] = cur[i];
        rej0 = model_reject(1'b1);
        rej1 = model_reject(1'b0);
        k = 0;
        while (!a_cfg_done && k < 80) begin
            tick();
            k++;
        end
        check("cfg_done_latency", k, N);
        check("cfg_done_perm", b_cfg_done, 1);
        check("cfg_err_inv", a_cfg_err, rej0);
        check("cfg_err_perm", b_cfg_err, rej1);
        mok[0][bank] = !rej0;
        mok[1][bank] = !rej1;
        check("bank_ok_inv", a_bank_ok, {mok[0][1], mok[0][0]});
        check("bank_ok_perm", b_bank_ok, {mok[1][1], mok[1][0]});
        tick();
        check("cfg_done_pulse", a_cfg_done, 0);
        check("cfg_busy_after", a_cfg_busy, 0);
    endtask

    task automatic send_char(input logic [7:0] c, input int bank, input bit d);
        int k;
        din = c; in_bank = bank[0]; dec = d;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        k = 0;
        while (!a_in_ready && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check("in_ready_timeout", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("out_valid_after_accept", a_out_valid, 1);
    endtask

    task automatic check_char(input string name, input logic [7:0] c, input int bank, input bit d);
        logic [8:0] e0, e1;
        send_char(c, bank, d);
        e0 = model_out(c, bank, d, 0);
        e1 = model_out(c, bank, d, 1);
        check({name, "_dout_inv"}, a_dout, e0[7:0]);
        check({name, "_err_inv"}, a_out_err, e0[8]);
        check({name, "_dout_perm"}, b_dout, e1[7:0]);
        check({name, "_err_perm"}, b_out_err, e1[8]);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic stream_hello(input int stall_at, input int stall_len, input int exp_iters);
        logic [7:0] msg [5];
        logic [8:0] e;
        logic [7:0] prev_dout;
        bit prev_hold;
        int sent, got, iter;
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        sent = 0; got = 0; prev_hold = 1'b0; prev_dout = 8'h00;
        in_bank = 1'b0; dec = 1'b0;
        for (iter = 0; iter < 40 && got < 5; iter++) begin
            in_valid = (sent < 5);
            if (sent < 5) din = msg[sent];
            out_ready = !(iter >= stall_at && iter < stall_at + stall_len);
            #1;
            if (prev_hold) begin
                check("hold_valid", a_out_valid, 1);
                check("hold_dout", a_dout, prev_dout);
            end
            if (a_out_valid && out_ready) begin
                e = model_out(msg[got], 0, 1'b0, 0);
                check("stream_dout", a_dout, e[7:0]);
                check("stream_dout_perm", b_dout, e[7:0]);
                got++;
            end
            prev_hold = a_out_valid && !out_ready;
            prev_dout = a_dout;
            if (in_valid && a_in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 5);
        check("stream_cycles", iter, exp_iters);
    endtask

    initial begin
        logic [8:0] e;
        int busy;
        bit rej0, rej1;

        reset = 1'b1; cfg_start = 1'b0; cfg_bank = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; din = '0; in_bank = 1'b0; dec = 1'b0; out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            mok[0][b] = 1'b0;
            mok[1][b] = 1'b0;
        end
        tick(); tick();
        check("rst_dout", a_dout, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_err", a_out_err, 0);
        check("rst_cfg_busy", a_cfg_busy, 0);
        check("rst_cfg_done", a_cfg_done, 0);
        check("rst_cfg_err", a_cfg_err, 0);
        check("rst_bank_ok_inv", a_bank_ok, 0);
        check("rst_bank_ok_perm", b_bank_ok, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < N; i++) cur[i] = i ^ 1;
        load_bank(0, 1'b1, -1);
        cur[0] = 0;
        for (int i = 1; i < 25; i++) cur[i] = (i % 2 == 1) ? i + 1 : i - 1;
        cur[25] = 25;
        load_bank(1, 1'b0, -1);

        vecs[0] = '{8'h41, 0, 1'b0, 8'h42, 1'b0};
        vecs[1] = '{8'h5A, 0, 1'b0, 8'h59, 1'b0};
        vecs[2] = '{8'h41, 0, 1'b1, 8'h42, 1'b0};
        vecs[3] = '{8'h5A, 0, 1'b1, 8'h59, 1'b0};
        vecs[4] = '{8'h4D, 0, 1'b0, 8'h4E, 1'b0};
        vecs[5] = '{8'h21, 0, 1'b0, 8'h21, 1'b0};
        vecs[6] = '{8'h40, 0, 1'b0, 8'h40, 1'b0};
        vecs[7] = '{8'h5B, 0, 1'b0, 8'h5B, 1'b0};
        vecs[8] = '{8'h43, 1, 1'b0, 8'h43, 1'b1};
        vecs[9] = '{8'h21, 1, 1'b0, 8'h21, 1'b0};
        for (int v = 0; v < 10; v++) begin
            send_char(vecs[v].din, vecs[v].bank, vecs[v].dec);
            check($sformatf("vec%0d_dout", v), a_dout, vecs[v].exp_dout);
            check($sformatf("vec%0d_err", v), a_out_err, vecs[v].exp_err);
            e = model_out(vecs[v].din, vecs[v].bank, vecs[v].dec, 1);
            check($sformatf("vec%0d_dout_perm", v), b_dout, e[7:0]);
            check($sformatf("vec%0d_err_perm", v), b_out_err, e[8]);
        end

        drain();
        stream_hello(100, 0, 6);
        drain();
        stream_hello(2, 3, 9);
        drain();

        // Reconfigure bank 1 while a bank-0 result is still waiting downstream.
        gen_table(0);
        for (int i = 0; i < N; i++) mtbl[1][i] = cur[i];
        mok[0][1] = 1'b0; mok[1][1] = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; din = 8'h41; in_bank = 1'b0; dec = 1'b0;
        cfg_start = 1'b1; cfg_bank = 1'b1;
        #1;
        check("busy_pre_ready", a_in_ready, 1);
        tick();
        cfg_start = 1'b0;
        check("busy_pending_valid", a_out_valid, 1);
        check("busy_pending_dout", a_dout, 8'h42);
        out_ready = 1'b1;
        busy = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc < N) begin
                cfg_valid = 1'b1;
                cfg_data = cur[cyc][4:0];
            end else begin
                cfg_valid = 1'b0;
            end
            #1;
            if (a_in_ready) break;
            busy++;
            if (cyc == 1) check("busy_drained", a_out_valid, 0);
            if (cyc == 40) check("busy_bank0_kept", a_bank_ok[0], 1);
            tick();
        end
        cfg_valid = 1'b0;
        check("busy_cycles", busy, 2 * N);
        check("busy_cfg_done", a_cfg_done, 1);
        rej0 = model_reject(1'b1);
        rej1 = model_reject(1'b0);
        mok[0][1] = !rej0; mok[1][1] = !rej1;
        check("busy_bank_ok_inv", a_bank_ok, {mok[0][1], mok[0][0]});
        check("busy_bank_ok_perm", b_bank_ok, {mok[1][1], mok[1][0]});
        tick();
        in_valid = 1'b0;
        check("busy_resumed_valid", a_out_valid, 1);
        check("busy_resumed_dout", a_dout, 8'h42);
        drain();

        for (int i = 0; i < N; i++) cur[i] = (i + 1) % N;
        load_bank(1, 1'b0, -1);
        send_char(8'h41, 1, 1'b0);
        check("rot_fwd_perm", b_dout, 8'h42);
        check("rot_fwd_err_perm", b_out_err, 0);
        check("rot_fwd_inv_passthru", a_dout, 8'h41);
        check("rot_fwd_inv_err", a_out_err, 1);
        send_char(8'h41, 1, 1'b1);
        check("rot_dec_perm", b_dout, 8'h5A);
        cur[3] = 7; cur[4] = 7;
        load_bank(1, 1'b1, -1);
        check("dup_rejected_perm", b_bank_ok[1], 0);

        for (int i = 0; i < N; i++) cur[i] = i ^ 1;
        load_bank(1, 1'b0, 8);
        check("restart_ignored_bank0", a_bank_ok[0], 1);

        drain();
        cfg_bank = 1'b0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_data = cur[i][4:0];
            tick();
        end
        cfg_valid = 1'b0;
        check("midload_busy", a_cfg_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_rst_busy", a_cfg_busy, 0);
        check("midload_rst_bank_ok_inv", a_bank_ok, 0);
        check("midload_rst_bank_ok_perm", b_bank_ok, 0);
        check("midload_rst_out_valid", a_out_valid, 0);
        check("midload_rst_in_ready", a_in_ready, 1);
        for (int b = 0; b < 2; b++) begin
            mok[0][b] = 1'b0;
            mok[1][b] = 1'b0;
        end
        for (int i = 0; i < 10; i++) mtbl[0][i] = cur[i];
        check_char("after_reset", 8'h41, 0, 1'b0);

        for (int round = 0; round < 4; round++) begin
            for (int b = 0; b < 2; b++) begin
                gen_table(int'($urandom_range(0, 2)));
                load_bank(b, 1'($urandom_range(0, 1)), -1);
            end
            for (int n = 0; n < 30; n++) begin
                logic [7:0] c;
                if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(8'h20, 8'h7E));
                else c = BASE + 8'($urandom_range(0, N-1));
                check_char("rand", c, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
